// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM encoding and counter sizing.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(WIDTH/DIGIT), never narrower than one bit.
  function automatic int cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/busy/done request-response bundle for serial_addsub.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub_digit_adder.sv
// DIGIT-bit ripple slice: one full-adder cell per bit, purely combinational.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
    assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
  end

  assign c_out = c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LS digit first,
// with signed-overflow detection and back-to-back start from DONE.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t st, st_nx;
  logic   accept, last;

  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic [WIDTH-1:0] b_eff, s_ext, acc_nx;
  logic [CW-1:0]    cnt;
  logic             carry, a_msb, b_msb;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic [DIGIT-1:0] s_d;
  logic             c_o;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx  = st;
    accept = 1'b0;
    last   = 1'b0;
    case (st)
      IDLE: if (bus.start) begin
        st_nx  = RUN;
        accept = 1'b1;
      end
      RUN: if (cnt == LAST) begin
        st_nx = DONE;
        last  = 1'b1;
      end
      DONE: begin
        if (bus.start) begin
          st_nx  = RUN;
          accept = 1'b1;
        end else begin
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // Subtract folds into add: a + ~b + ~cin.
  assign b_eff = bus.sub ? ~bus.b : bus.b;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a_d   (a_sr[DIGIT-1:0]),
    .b_d   (b_sr[DIGIT-1:0]),
    .c_in  (carry),
    .s_d   (s_d),
    .c_out (c_o)
  );

  // New digit enters at the top of the accumulator; after N shifts it is aligned.
  assign s_ext  = WIDTH'(s_d);
  assign acc_nx = (acc >> DIGIT) | (s_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= b_eff;
      carry <= bus.cin ^ bus.sub;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= b_eff[WIDTH-1];
      cnt   <= '0;
    end else if (st == RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      carry <= c_o;
      acc   <= acc_nx;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_q  <= acc_nx;
        cout_q <= c_o;
        ovf_q  <= (a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb);
      end
    end
  end

  assign bus.busy = (st == RUN);
  assign bus.done = (st == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
